// File: rtl/scan_drv_pkg.sv
// Shared definitions for the scan chain driver: FSM state encoding and the
// phase-counter width helper.
package scan_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CAPT   = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  // Wide enough to hold the longest phase length (shift or capture).
  function automatic int cnt_width(input int chain_len, input int cap_cyc);
    int longest;
    longest = (chain_len > cap_cyc) ? chain_len : cap_cyc;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/scan_drv_shreg.sv
// CHAIN_LEN-bit left-shifting register: parallel load, MSB-first serial out,
// LSB serial in, parallel out. Serves as both pattern source and response sink.
module scan_drv_shreg #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_val,
  input  logic                 en,
  input  logic                 ser_in,
  output logic [CHAIN_LEN-1:0] par_out,
  output logic                 ser_out
);

  logic [CHAIN_LEN-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (clear) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_val;
    end else if (en) begin
      data_q <= {data_q[CHAIN_LEN-2:0], ser_in};
    end
  end

  assign par_out = data_q;
  assign ser_out = data_q[CHAIN_LEN-1];

endmodule

// File: rtl/scan_chain_driver.sv
// Load/capture/unload sequencer for one scan chain: shifts PAT in on SI,
// captures for CAP_CYC cycles, shifts the response in from SO, masked compare.
module scan_chain_driver #(
  parameter int   CHAIN_LEN = 16,
  parameter int   CAP_CYC   = 1,
  parameter logic FILL      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic [CHAIN_LEN-1:0] MASK,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 FAIL
);

  import scan_drv_pkg::*;

  localparam int            CW       = cnt_width(CHAIN_LEN, CAP_CYC);
  localparam logic [CW-1:0] LEN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAP_CYC - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] exp_q, mask_q;
  logic [CHAIN_LEN-1:0] resp_shift;
  logic                 accept, shift_en, shift_in, sr_msb;
  logic                 se_d, si_d, busy_d, done_d, fail_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    shift_in = FILL;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shift_en = 1'b1;
        if (cnt_q == LEN_LAST) begin
          state_d = ST_CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CAPT: begin
        if (cnt_q == CAP_LAST) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_UNLOAD: begin
        shift_en = 1'b1;
        shift_in = SO;
        if (cnt_q == LEN_LAST) begin
          state_d = ST_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so the chain sees them
    // change only at CLK edges and stay stable for the whole cycle.
    se_d   = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_CAPT) || (state_d == ST_UNLOAD);
    done_d = (state_d == ST_FIN);

    if (accept) begin
      si_d = PAT[CHAIN_LEN-1];
    end else if (state_q == ST_LOAD && state_d == ST_LOAD) begin
      si_d = sr_msb;
    end else if (state_d == ST_UNLOAD) begin
      si_d = FILL;
    end else begin
      si_d = 1'b0;
    end

    // Compare against the response as it will look after the final unload edge.
    resp_shift = {RESP[CHAIN_LEN-2:0], SO};
    fail_d     = FAIL;
    if (accept) begin
      fail_d = 1'b0;
    end else if (state_q == ST_UNLOAD && state_d == ST_FIN) begin
      fail_d = |((resp_shift ^ exp_q) & mask_q);
    end
  end

  // NOTE: the latched EXP/MASK copies are reset along with the control state,
  // so nothing downstream ever observes uninitialised contents after RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      SE      <= 1'b0;
      SI      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      FAIL    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      SE      <= se_d;
      SI      <= si_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      FAIL    <= fail_d;
      if (accept) begin
        exp_q  <= EXP;
        mask_q <= MASK;
      end
    end
  end

  // PAT's MSB leaves on SI at acceptance, so the register keeps the remainder;
  // after LOAD it has shifted out to zeros and UNLOAD refills it from SO.
  scan_drv_shreg #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shreg (
    .clk     (CLK),
    .clear   (RST),
    .load    (accept),
    .load_val({PAT[CHAIN_LEN-2:0], 1'b0}),
    .en      (shift_en),
    .ser_in  (shift_in),
    .par_out (RESP),
    .ser_out (sr_msb)
  );

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench: a 4-flop inverting-capture chain and a 16-flop transparent
// chain, each modelled as scan flops driven by its own scan_chain_driver.
module tb_scan_chain_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  // 4-flop chain, functional D = ~Q
  logic       start_a, so_a, se_a, si_a, busy_a, done_a, fail_a;
  logic [3:0] pat_a, exp_a, mask_a, resp_a;
  logic [3:0] chain_a = '0;

  // 16-flop chain, CAP_CYC=3, functional D = Q
  logic        start_b, so_b, se_b, si_b, busy_b, done_b, fail_b;
  logic [15:0] pat_b, exp_b, mask_b, resp_b;
  logic [15:0] chain_b = '0;

  always @(posedge clk) chain_a <= se_a ? {chain_a[2:0], si_a} : ~chain_a;
  always @(posedge clk) chain_b <= se_b ? {chain_b[14:0], si_b} : chain_b;
  assign so_a = chain_a[3];
  assign so_b = chain_b[15];

  scan_chain_driver #(.CHAIN_LEN(4), .CAP_CYC(1), .FILL(1'b0)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .PAT(pat_a), .EXP(exp_a), .MASK(mask_a),
    .SO(so_a), .SE(se_a), .SI(si_a), .BUSY(busy_a), .DONE(done_a), .RESP(resp_a), .FAIL(fail_a)
  );

  scan_chain_driver #(.CHAIN_LEN(16), .CAP_CYC(3), .FILL(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .PAT(pat_b), .EXP(exp_b), .MASK(mask_b),
    .SO(so_b), .SE(se_b), .SI(si_b), .BUSY(busy_b), .DONE(done_b), .RESP(resp_b), .FAIL(fail_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  // One full sequence on the 4-flop chain with cycle-exact checks.
  task automatic run_a(input logic [3:0] pat, input logic [3:0] expv, input logic [3:0] mask,
                       input logic [3:0] want_resp, input logic want_fail);
    @(negedge clk);
    start_a = 1'b1; pat_a = pat; exp_a = expv; mask_a = mask;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("accept_clears_fail", 32'(fail_a), 32'(0));
        // Scramble inputs: the run must use the copies latched at acceptance.
        start_a = 1'b0; pat_a = ~pat; exp_a = ~expv; mask_a = ~mask;
      end
      if (c <= 4) begin
        check("load_se", 32'(se_a), 32'(1));
        check("load_si", 32'(si_a), 32'(pat[4-c]));
      end else if (c == 5) begin
        check("capt_se_si_busy", 32'({se_a, si_a, busy_a}), 32'(3'b001));
        check("chain_loaded", 32'(chain_a), 32'(pat));
      end else if (c <= 9) begin
        check("unload_se_si_busy_done", 32'({se_a, si_a, busy_a, done_a}), 32'(4'b1010));
      end else begin
        check("done_pulse", 32'({done_a, busy_a}), 32'(2'b10));
        check("resp", 32'(resp_a), 32'(want_resp));
        check("fail", 32'(fail_a), 32'(want_fail));
      end
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done_a), 32'(0));
  endtask

  initial begin
    int n_done, first_done, second_done;
    rst = 1'b1;
    start_a = 1'b0; pat_a = '0; exp_a = '0; mask_a = '0;
    start_b = 1'b0; pat_b = '0; exp_b = '0; mask_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("reset_idle", 32'({se_a, si_a, busy_a, done_a, fail_a, resp_a}), 32'(0));
    end

    // Inverting capture: RESP = ~PAT
    run_a(4'b1010, 4'b0101, 4'hF,    4'b0101, 1'b0);
    run_a(4'b1010, 4'b0111, 4'hF,    4'b0101, 1'b1);
    repeat (3) @(negedge clk);
    check("fail_holds", 32'({fail_a, resp_a}), 32'(5'b10101));
    run_a(4'b1010, 4'b0111, 4'b1101, 4'b0101, 1'b0);
    run_a(4'b0011, 4'b1100, 4'hF,    4'b1100, 1'b0);
    run_a(4'b0110, 4'b0000, 4'h0,    4'b1001, 1'b0);

    // START held high: second run begins on the DONE edge
    @(negedge clk);
    start_a = 1'b1; pat_a = 4'b1010; exp_a = 4'b0101; mask_a = 4'hF;
    n_done = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (done_a) begin
        n_done++;
        if (first_done == 0) first_done = c; else second_done = c;
      end
      if (c == 11) check("b2b_busy", 32'(busy_a), 32'(1));
      if (c == 20) start_a = 1'b0;
      if (c == 21) check("b2b_idle", 32'(busy_a), 32'(0));
    end
    check("b2b_done_count", 32'(n_done), 32'(2));
    check("b2b_first_done", 32'(first_done), 32'(10));
    check("b2b_second_done", 32'(second_done), 32'(20));
    check("b2b_resp", 32'(resp_a), 32'(4'b0101));

    // START pulses while busy are ignored
    @(negedge clk);
    start_a = 1'b1; pat_a = 4'b0011; exp_a = 4'b1100; mask_a = 4'hF;
    n_done = 0; first_done = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (done_a) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      start_a = (c == 3) || (c == 7);
    end
    check("busy_ignore_done_count", 32'(n_done), 32'(1));
    check("busy_ignore_done_cycle", 32'(first_done), 32'(10));

    // Reset in the third unload cycle
    @(negedge clk);
    start_a = 1'b1; pat_a = 4'b1010; exp_a = 4'b0101; mask_a = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 8) begin
        check("third_unload_active", 32'({se_a, busy_a}), 32'(2'b11));
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check("mid_unload_reset", 32'({se_a, busy_a, done_a, fail_a, resp_a}), 32'(0));
    rst = 1'b0;
    run_a(4'b0011, 4'b1100, 4'hF, 4'b1100, 1'b0);

    // 16-flop chain, transparent capture, 3 capture cycles
    @(negedge clk);
    start_b = 1'b1; pat_b = 16'hA5C3; exp_b = 16'hA5C3; mask_b = 16'hFFFF;
    first_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (c == 1) check("b_load_start", 32'({se_b, si_b, busy_b}), 32'(3'b111));
      if (done_b && first_done == 0) begin
        first_done = c;
        check("b_resp", 32'(resp_b), 32'(16'hA5C3));
        check("b_fail", 32'(fail_b), 32'(0));
      end
    end
    check("b_done_cycle", 32'(first_done), 32'(36));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
